// File: rtl/dm_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// State encoding, default timeout and datapath word width.
package dm_access_ctrl_pkg;

  localparam int WORD_W          = 16;
  localparam int DEFAULT_TIMEOUT = 64;
  localparam int DEFAULT_CNT_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } dm_state_e;

endpackage

// File: rtl/dm_access_ctrl_timeout.sv
// Wait-cycle counter for the memory stage; flags the last allowed
// WAIT cycle so the controller can abort a hung access.
import dm_access_ctrl_pkg::*;

module dm_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // clear on issue, count every waiting cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = i_en &&
    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dm_access_ctrl.sv
// Memory-stage controller: one multi-cycle data-memory access per
// instruction, stalling the pipe. Optional macro: DM_ALIGN_CHECK_EN.
import dm_access_ctrl_pkg::*;

module dm_access_ctrl #(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] EXDM_ALU,
  input  logic [WORD_W-1:0] EXDM_RTData,
  input  logic              EXDM_MemRead,
  input  logic              EXDM_MemWrt,
  input  logic              EXDM_HaltSig,
  input  logic              EXDM_err,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_err,
  output logic [WORD_W-1:0] DM_rdata,
  output logic              DM_valid,
  output logic              DM_stall,
  output logic              DM_err,
  output logic              DM_HaltSig
);

  dm_state_e r_state;
  dm_state_e w_state_nxt;
  logic      r_is_load;
  logic      w_misalign;
  logic      w_go;
  logic      w_bad;
  logic      w_idle;
  logic      w_accept;
  logic      w_reject;
  logic      w_wait;
  logic      w_wait_end;
  logic      w_expired;

`ifdef DM_ALIGN_CHECK_EN
  assign w_misalign = EXDM_ALU[0];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_go = (EXDM_MemRead ^ EXDM_MemWrt)
              & ~EXDM_err & ~w_misalign;
  assign w_bad = EXDM_err
               | (EXDM_MemRead & EXDM_MemWrt)
               | ((EXDM_MemRead | EXDM_MemWrt) & w_misalign);

  assign w_idle     = (r_state == ST_IDLE);
  assign w_wait     = (r_state == ST_WAIT);
  assign w_accept   = w_idle & w_go;
  assign w_reject   = w_idle & w_bad;
  assign w_wait_end = w_wait & (mem_done | w_expired);

  // stall is immediate on a new request and dropped in DONE
  assign DM_stall = ~rst & (w_accept
                  | (r_state == ST_ISSUE) | w_wait);

  dm_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == ST_ISSUE),
    .i_en      (w_wait),
    .o_expired (w_expired)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state; DONE never looks at the still-held request
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_go) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (mem_done | w_expired) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // request capture and single-cycle strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      r_is_load <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      mem_rd <= w_accept & EXDM_MemRead;
      mem_wr <= w_accept & EXDM_MemWrt;
      if (w_accept) begin
        mem_addr  <= EXDM_ALU;
        mem_wdata <= EXDM_RTData;
        r_is_load <= EXDM_MemRead;
      end
    end
  end

  // completion status towards DM/WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DM_valid <= 1'b0;
      DM_err   <= 1'b0;
      DM_rdata <= '0;
    end else begin
      DM_valid <= w_reject | w_wait_end;
      if (w_accept)
        DM_err <= 1'b0;
      else if (w_reject)
        DM_err <= 1'b1;
      else if (w_wait_end)
        DM_err <= mem_done ? mem_err : 1'b1;
      if (w_wait & mem_done & r_is_load)
        DM_rdata <= mem_rdata;
    end
  end

  // halt marker follows the pipe only while it advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            DM_HaltSig <= 1'b0;
    else if (!DM_stall) DM_HaltSig <= EXDM_HaltSig;
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Memory-stage consumer of the EX/DM pipeline register outputs.
- Takes the latched ALU address, RT store data and the MemRead/MemWrt/halt/err controls, and runs one multi-cycle data-memory transaction per instruction.
- Stalls the pipeline while the transaction is in flight.
- Hands load data and status to the DM/WB boundary.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT before the access is aborted with an error.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- EXDM_ALU  in  16  effective address.
- EXDM_RTData  in  16  store data.
- EXDM_MemRead  in  1  load request.
- EXDM_MemWrt  in  1  store request.
- EXDM_HaltSig  in  1  halt marker, passed through.
- EXDM_err  in  1  upstream error, passed through.
- mem_addr  out  16  memory address (registered).
- mem_wdata  out  16  memory write data (registered).
- mem_rd  out  1  read strobe, one cycle.
- mem_wr  out  1  write strobe, one cycle.
- mem_rdata  in  16  memory read data, valid with mem_done.
- mem_done  in  1  transaction complete.
- mem_err  in  1  memory fault, sampled with mem_done.
- DM_rdata  out  16  load result.
- DM_valid  out  1  one-cycle completion pulse.
- DM_stall  out  1  hold PC, IF/ID, ID/EX and EX/DM.
- DM_err  out  1  sticky-until-next-access error to the DM/WB boundary.
- DM_HaltSig  out  1  registered copy of EXDM_HaltSig.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; counter = 0.
  - mem_addr = mem_wdata = DM_rdata = 16'h0000.
  - mem_rd = mem_wr = DM_valid = DM_err = DM_HaltSig = 0.
  - DM_stall = 0. DM_stall is combinational from state, so it is 0 immediately on reset.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, request = (MemRead xor MemWrt) & ~EXDM_err:
  - DM_stall = 1 combinationally in the same cycle.
  - Capture EXDM_ALU into mem_addr and EXDM_RTData into mem_wdata.
  - Latch the access type; clear DM_err; next state ISSUE.
- IDLE, both MemRead and MemWrt = 1:
  - No access; DM_err = 1 next cycle; DM_valid pulses; no stall.
- IDLE, EXDM_err = 1:
  - No access; DM_err = 1 next cycle; DM_valid pulses.
- IDLE, no request:
  - DM_valid = 0; DM_err holds its value.
- ISSUE:
  - Exactly one of mem_rd/mem_wr = 1 for this single cycle.
  - Counter cleared; DM_stall = 1; next state WAIT.
- WAIT:
  - DM_stall = 1; counter increments each cycle.
  - On mem_done: capture mem_rdata into DM_rdata (loads only; stores leave DM_rdata unchanged) and set DM_err = mem_err; next state DONE.
  - mem_done takes priority over timeout in the same cycle.
  - Timeout: counter == TIMEOUT_CYCLES-1 without mem_done sets DM_err = 1 and goes to DONE; DM_rdata unchanged.
- DONE:
  - DM_valid = 1 and DM_stall = 0 for one cycle, so the pipeline advances; next state IDLE.
  - The stalled EX/DM request is still present on the inputs in this cycle and must not be re-accepted.
- mem_done outside WAIT is ignored.
- DM_HaltSig registers EXDM_HaltSig every cycle DM_stall = 0 and holds while stalled.
- Minimum load latency with a zero-wait memory (mem_done in the first WAIT cycle): request seen in cycle 0, DM_valid in cycle 3; stall cycles = 3.
- Reset mid-transaction aborts it immediately; no strobe is reissued.

Optional Feature:
- Macro: DM_ALIGN_CHECK_EN.
- Defined: a request with EXDM_ALU[0] = 1 is treated as misaligned. No strobe is issued; DM_err = 1 and DM_valid pulses next cycle; no stall.
- Undefined: bit 0 is ignored and the address is passed through unchanged.

Decomposition:
- Shared package:
  - state encoding (2-bit IDLE = 0, ISSUE = 1, WAIT = 2, DONE = 3);
  - DEFAULT_TIMEOUT constant;
  - word width 16.
- The timeout counter is a natural sub-module: dm_timeout_ctr, with clear, enable and expired outputs.
- Output registers reuse the existing register/dff cells.

Test Plan:
- Load, addr 16'h0040, mem_done in the first WAIT cycle with rdata 16'hBEEF:
  - mem_rd high exactly in cycle 1;
  - DM_stall high in cycles 0–2;
  - DM_valid in cycle 3 with DM_rdata = 16'hBEEF and DM_err = 0.
- Store, addr 16'h0102, data 16'h1234, mem_done after 5 WAIT cycles:
  - mem_wr high one cycle with mem_addr = 16'h0102 and mem_wdata = 16'h1234;
  - DM_rdata unchanged; DM_valid once; DM_stall = 1 for 7 cycles (IDLE detect + ISSUE + 5 WAIT).
- No mem_done, TIMEOUT_CYCLES = 4:
  - 4 WAIT cycles, then DM_err = 1 and DM_valid pulse;
  - the following no-request cycle keeps DM_err = 1;
  - the next valid access clears it.
- MemRead = MemWrt = 1, or EXDM_err = 1:
  - no mem_rd/mem_wr;
  - DM_err = 1 and DM_valid next cycle; DM_stall never asserted.
- rst asserted in WAIT:
  - outputs return to reset values immediately, with no clock edge needed;
  - with the request still present after reset release, exactly one new ISSUE is performed.
- With DM_ALIGN_CHECK_EN, load addr 16'h0041:
  - no strobe; DM_err = 1 next cycle.
- Without the macro, same load:
  - normal access with mem_addr = 16'h0041.
